// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions for the ID/EX boundary.
package id_ex_stage_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned ALUOP_W   = 4;
    localparam int unsigned XLEN      = 32;

    typedef enum logic [ALUOP_W-1:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluNor  = 4'd5,
        AluSlt  = 4'd6,
        AluSltu = 4'd7,
        AluSll  = 4'd8,
        AluSrl  = 4'd9,
        AluSra  = 4'd10,
        AluLui  = 4'd11
    } alu_op_e;

    // Everything the EX stage and forwarding unit see from the ID/EX register.
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rs;
        logic [REG_IDX_W-1:0] rt;
        logic [REG_IDX_W-1:0] rd;
        logic                 we;
        logic                 mem_read;
        logic                 mem_write;
        logic                 alusrc_imm;
        alu_op_e              aluop;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      rs_data;
        logic [XLEN-1:0]      rt_data;
        logic [XLEN-1:0]      pc;
    } ex_regs_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the ID instruction.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    output logic                 hazard
);

    logic rs_match;
    logic rt_match;

    // Register 0 is hardwired, so a load targeting it never needs a stall.
    always_comb begin
        rs_match = id_uses_rs && (id_rs == ex_rd);
        rt_match = id_uses_rt && (id_rt == ex_rd);
        hazard   = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid
                   && (rs_match || rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, freeze and bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_we,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 id_alusrc_imm,
    input  logic [ALUOP_W-1:0]   id_aluop,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [XLEN-1:0]      id_rs_data,
    input  logic [XLEN-1:0]      id_rt_data,
    input  logic [XLEN-1:0]      id_pc,
    input  logic                 flush,
    input  logic                 mem_busy,
    output logic                 ex_valid,
    output logic [REG_IDX_W-1:0] ex_rs,
    output logic [REG_IDX_W-1:0] ex_rt,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic                 ex_we,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_alusrc_imm,
    output logic [ALUOP_W-1:0]   ex_aluop,
    output logic [XLEN-1:0]      ex_imm,
    output logic [XLEN-1:0]      ex_rs_data,
    output logic [XLEN-1:0]      ex_rt_data,
    output logic [XLEN-1:0]      ex_pc,
    output logic                 pc_we,
    output logic                 if_id_we,
    output logic [CNT_W-1:0]     bubble_cnt
);

    ex_regs_t         ex_d, ex_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic             hazard;

    load_use_detect u_load_use_detect (
        .ex_valid    (ex_q.valid),
        .ex_mem_read (ex_q.mem_read),
        .ex_rd       (ex_q.rd),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .hazard      (hazard)
    );

    // Next-state and front-end write enables; priority rst > mem_busy > flush > hazard > load.
    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if (rst) begin
            // Register clears in the sequential block; front end keeps advancing.
        end else if (mem_busy) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
        end else if (flush) begin
            ex_d = '0;
        end else if (hazard) begin
            ex_d     = '0;
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_d.valid      = id_valid;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.rd         = id_rd;
            // A non-instruction must never write state, whatever the decoder produced.
            ex_d.we         = id_valid && id_we;
            ex_d.mem_read   = id_valid && id_mem_read;
            ex_d.mem_write  = id_valid && id_mem_write;
            ex_d.alusrc_imm = id_alusrc_imm;
            ex_d.aluop      = alu_op_e'(id_aluop);
            ex_d.imm        = id_imm;
            ex_d.rs_data    = id_rs_data;
            ex_d.rt_data    = id_rt_data;
            ex_d.pc         = id_pc;
        end
    end

    // ID/EX register and bubble counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Drive the flat output ports from the register.
    always_comb begin
        ex_valid      = ex_q.valid;
        ex_rs         = ex_q.rs;
        ex_rt         = ex_q.rt;
        ex_rd         = ex_q.rd;
        ex_we         = ex_q.we;
        ex_mem_read   = ex_q.mem_read;
        ex_mem_write  = ex_q.mem_write;
        ex_alusrc_imm = ex_q.alusrc_imm;
        ex_aluop      = ex_q.aluop;
        ex_imm        = ex_q.imm;
        ex_rs_data    = ex_q.rs_data;
        ex_rt_data    = ex_q.rt_data;
        ex_pc         = ex_q.pc;
        bubble_cnt    = bubble_cnt_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table plus scoreboard of expected EX state.
module tb_id_ex_stage;

    localparam int unsigned CntW = 2;

    logic        clk = 1'b0;
    logic        rst, id_valid, id_uses_rs, id_uses_rt;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_we, id_mem_read, id_mem_write, id_alusrc_imm;
    logic [3:0]  id_aluop;
    logic [31:0] id_imm, id_rs_data, id_rt_data, id_pc;
    logic        flush, mem_busy;
    logic        ex_valid, ex_we, ex_mem_read, ex_mem_write, ex_alusrc_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [3:0]  ex_aluop;
    logic [31:0] ex_imm, ex_rs_data, ex_rt_data, ex_pc;
    logic        pc_we, if_id_we;
    logic [CntW-1:0] bubble_cnt;

    id_ex_stage #(.CNT_W(CntW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_we(id_we),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_alusrc_imm(id_alusrc_imm), .id_aluop(id_aluop), .id_imm(id_imm),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_pc(id_pc), .flush(flush),
        .mem_busy(mem_busy), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alusrc_imm(ex_alusrc_imm), .ex_aluop(ex_aluop),
        .ex_imm(ex_imm), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_pc(ex_pc),
        .pc_we(pc_we), .if_id_we(if_id_we), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, bsy, fl, vl;
        logic [4:0] rs, rt;
        logic urs, urt;
        logic [4:0] rd;
        logic we, mr, mw;
        logic [3:0] op;
        int tag;
        logic epc, ev;
        logic [4:0] ers, ert, erd;
        logic ewe, emr, emw;
        logic [3:0] eop;
        int etag, ecnt;
    } vec_t;

    typedef struct {
        logic ev;
        logic [4:0] ers, ert, erd;
        logic ewe, emr, emw;
        logic [3:0] eop;
        int etag, ecnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Payload fields are a function of a tag; tag 0 means an all-zero (bubble) payload.
    function automatic logic [31:0] d_imm(input int t);
        return (t == 0) ? 32'h0 : (32'h1000_0000 | 32'(t));
    endfunction
    function automatic logic [31:0] d_rs(input int t);
        return (t == 0) ? 32'h0 : (32'hA000_0000 | 32'(t));
    endfunction
    function automatic logic [31:0] d_rt(input int t);
        return (t == 0) ? 32'h0 : (32'hB000_0000 | 32'(t));
    endfunction
    function automatic logic [31:0] d_pc(input int t);
        return (t == 0) ? 32'h0 : (32'(t) << 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic add(input logic r, bsy, fl, vl, input logic [4:0] rs, rt,
                       input logic urs, urt, input logic [4:0] rd, input logic we, mr, mw,
                       input logic [3:0] op, input int tag, input logic epc, ev,
                       input logic [4:0] ers, ert, erd, input logic ewe, emr, emw,
                       input logic [3:0] eop, input int etag, ecnt);
        vec_t v;
        v.r = r; v.bsy = bsy; v.fl = fl; v.vl = vl; v.rs = rs; v.rt = rt;
        v.urs = urs; v.urt = urt; v.rd = rd; v.we = we; v.mr = mr; v.mw = mw;
        v.op = op; v.tag = tag; v.epc = epc; v.ev = ev; v.ers = ers; v.ert = ert;
        v.erd = erd; v.ewe = ewe; v.emr = emr; v.emw = emw; v.eop = eop;
        v.etag = etag; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst = v.r; mem_busy = v.bsy; flush = v.fl; id_valid = v.vl;
        id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt; id_rd = v.rd;
        id_we = v.we; id_mem_read = v.mr; id_mem_write = v.mw; id_aluop = v.op;
        id_alusrc_imm = v.tag[0];
        id_imm = d_imm(v.tag); id_rs_data = d_rs(v.tag);
        id_rt_data = d_rt(v.tag); id_pc = d_pc(v.tag);
        #1;
        chk($sformatf("v%0d pc_we", idx), {31'b0, pc_we}, {31'b0, v.epc});
        chk($sformatf("v%0d if_id_we", idx), {31'b0, if_id_we}, {31'b0, v.epc});
        e.ev = v.ev; e.ers = v.ers; e.ert = v.ert; e.erd = v.erd; e.ewe = v.ewe;
        e.emr = v.emr; e.emw = v.emw; e.eop = v.eop; e.etag = v.etag; e.ecnt = v.ecnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL v%0d scoreboard: got empty want entry", idx);
        end else begin
            g = sb.pop_front();
            chk($sformatf("v%0d ex_valid", idx), {31'b0, ex_valid}, {31'b0, g.ev});
            chk($sformatf("v%0d ex_rs", idx), {27'b0, ex_rs}, {27'b0, g.ers});
            chk($sformatf("v%0d ex_rt", idx), {27'b0, ex_rt}, {27'b0, g.ert});
            chk($sformatf("v%0d ex_rd", idx), {27'b0, ex_rd}, {27'b0, g.erd});
            chk($sformatf("v%0d ex_we", idx), {31'b0, ex_we}, {31'b0, g.ewe});
            chk($sformatf("v%0d ex_mem_read", idx), {31'b0, ex_mem_read}, {31'b0, g.emr});
            chk($sformatf("v%0d ex_mem_write", idx), {31'b0, ex_mem_write}, {31'b0, g.emw});
            chk($sformatf("v%0d ex_aluop", idx), {28'b0, ex_aluop}, {28'b0, g.eop});
            chk($sformatf("v%0d ex_alusrc_imm", idx), {31'b0, ex_alusrc_imm},
                32'(g.etag) & 32'h1);
            chk($sformatf("v%0d ex_imm", idx), ex_imm, d_imm(g.etag));
            chk($sformatf("v%0d ex_rs_data", idx), ex_rs_data, d_rs(g.etag));
            chk($sformatf("v%0d ex_rt_data", idx), ex_rt_data, d_rt(g.etag));
            chk($sformatf("v%0d ex_pc", idx), ex_pc, d_pc(g.etag));
            chk($sformatf("v%0d bubble_cnt", idx), {30'b0, bubble_cnt}, 32'(g.ecnt));
        end
    endtask

    initial begin
        rst = 1'b1; mem_busy = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_rd = '0;
        id_we = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_alusrc_imm = 1'b0;
        id_aluop = '0; id_imm = '0; id_rs_data = '0; id_rt_data = '0; id_pc = '0;

        // Initial reset overrides busy/flush with a live ID instruction.
        add(1,1,1,1, 3,4,1,1,5,1,1,1,7,31, 1, 0,0,0,0,0,0,0,0,0,0);
        //  r b f v  rs rt urs urt rd we mr mw op tag  pc  ev ers ert erd we mr mw op tag cnt
        add(0,0,0,1, 1,8,1,0,8,1,1,0,0,1,    1, 1,1,8,8,1,1,0,0,1,0);    // lw r8
        add(0,0,0,1, 8,3,1,1,10,1,0,0,1,2,   0, 0,0,0,0,0,0,0,0,0,1);    // load-use bubble
        add(0,0,0,1, 8,3,1,1,10,1,0,0,1,2,   1, 1,8,3,10,1,0,0,1,2,1);   // add proceeds
        add(0,0,0,1, 2,0,1,0,0,1,1,0,0,3,    1, 1,2,0,0,1,1,0,0,3,1);    // lw r0
        add(0,0,0,1, 0,0,1,1,11,1,0,0,1,4,   1, 1,0,0,11,1,0,0,1,4,1);   // r0 never stalls
        add(0,0,0,1, 3,9,1,0,9,1,1,0,0,5,    1, 1,3,9,9,1,1,0,0,5,1);    // lw r9
        add(0,0,0,1, 4,9,1,0,12,1,0,0,2,6,   1, 1,4,9,12,1,0,0,2,6,1);   // rt unused
        add(0,0,0,1, 5,13,1,0,13,1,1,0,0,7,  1, 1,5,13,13,1,1,0,0,7,1);  // lw r13
        add(0,0,1,1, 13,1,1,0,14,1,0,0,1,8,  1, 0,0,0,0,0,0,0,0,0,1);    // flush beats hazard
        add(0,0,0,0, 6,7,1,1,15,1,1,1,3,9,   1, 0,6,7,15,0,0,0,3,9,1);   // invalid kills ctrls
        add(0,0,0,1, 1,16,1,0,16,1,1,0,0,10, 1, 1,1,16,16,1,1,0,0,10,1); // lw r16
        add(0,0,0,0, 16,2,1,1,17,1,1,0,5,11, 1, 0,16,2,17,0,0,0,5,11,1); // invalid: no stall
        add(0,0,0,1, 1,18,1,0,18,1,1,0,0,12, 1, 1,1,18,18,1,1,0,0,12,1); // lw r18
        add(0,0,0,1, 2,18,1,1,0,0,0,1,0,13,  0, 0,0,0,0,0,0,0,0,0,2);    // sw: stall via rt
        add(0,0,0,1, 2,18,1,1,0,0,0,1,0,13,  1, 1,2,18,0,0,0,1,0,13,2);
        add(0,0,0,1, 1,20,1,0,20,1,1,0,0,14, 1, 1,1,20,20,1,1,0,0,14,2); // lw r20
        add(0,1,0,1, 20,0,1,0,21,1,0,0,1,15, 0, 1,1,20,20,1,1,0,0,14,2); // freeze over hazard
        add(0,1,1,1, 21,0,1,0,21,1,0,0,1,16, 0, 1,1,20,20,1,1,0,0,14,2); // freeze over flush
        add(0,1,0,1, 22,0,1,0,21,1,0,0,1,17, 0, 1,1,20,20,1,1,0,0,14,2);
        add(0,0,0,1, 1,0,1,0,21,1,0,0,1,18,  1, 1,1,0,21,1,0,0,1,18,2);  // release loads ID
        add(0,0,0,1, 1,22,1,0,22,1,1,0,0,19, 1, 1,1,22,22,1,1,0,0,19,2);
        add(0,0,0,1, 22,0,1,0,23,1,0,0,1,20, 0, 0,0,0,0,0,0,0,0,0,3);    // 3rd bubble
        add(0,0,0,1, 1,24,1,0,24,1,1,0,0,21, 1, 1,1,24,24,1,1,0,0,21,3);
        add(0,0,0,1, 24,0,1,0,25,1,0,0,1,22, 0, 0,0,0,0,0,0,0,0,0,3);    // saturated
        add(0,0,0,1, 1,28,1,0,28,1,1,0,0,25, 1, 1,1,28,28,1,1,0,0,25,3);
        add(0,0,0,1, 0,28,0,1,29,1,0,0,1,26, 0, 0,0,0,0,0,0,0,0,0,3);    // 5th bubble
        add(0,0,0,1, 1,26,1,0,26,1,1,0,0,23, 1, 1,1,26,26,1,1,0,0,23,3);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset while a load-use stall is pending: bubble discarded, then ID loads normally.
        vecs.delete();
        add(1,0,0,1, 26,0,1,0,27,1,0,0,1,24, 1, 0,0,0,0,0,0,0,0,0,0);
        add(0,0,0,1, 26,0,1,0,27,1,0,0,1,24, 1, 1,26,0,27,1,0,0,1,24,0);
        foreach (vecs[i]) run_vec(100 + i, vecs[i]);

        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
